// File: rtl/atm_keypad_entry_if.sv
// rtl/atm_keypad_entry_if.sv - keypad strobe, core handshake and display bundle for atm_keypad_entry
interface atm_keypad_entry_if;
   logic       key_valid;
   logic [3:0] key_code;
   logic       ack;
   logic [4:0] COD;
   logic [3:0] PIN;
   logic [3:0] VAL;
   logic       ENABLE;
   logic       Seleciona;
   logic [8:0] Tempo;
   logic       key_err;
   logic       timeout;
   logic       done;

   modport master (
      output key_valid, key_code, ack,
      input  COD, PIN, VAL, ENABLE, Seleciona, Tempo, key_err, timeout, done
   );

   modport slave (
      input  key_valid, key_code, ack,
      output COD, PIN, VAL, ENABLE, Seleciona, Tempo, key_err, timeout, done
   );
endinterface

// File: rtl/atm_keypad_entry.sv
// rtl/atm_keypad_entry.sv - keypad entry FSM assembling COD/PIN/VAL for the ATM core
// Inactivity timer on Tempo/timeout is built only when ATM_ENTRY_TIMEOUT_EN is defined.
module atm_keypad_entry #(
   parameter int TIMEOUT_CYCLES = 300
) (
   input logic               clk,
   input logic               reset,
   atm_keypad_entry_if.slave bus
);

   localparam logic [3:0] KEY_ENTER  = 4'hA;
   localparam logic [3:0] KEY_CANCEL = 4'hB;

   typedef enum logic [2:0] {IDLE, GET_COD, GET_PIN, GET_VAL, REQUEST} state_t;

   state_t     state, state_n;
   logic [4:0] cod, cod_n;
   logic [3:0] pin, pin_n;
   logic [3:0] val, val_n;
   logic       seen, seen_n;
   logic       enable_q, sel_q;
   logic       key_err_q, key_err_n;
   logic       timeout_q, timeout_n;
   logic       done_q, done_n;
   logic       expire;
   logic [7:0] field, fmax, cand;

   always_comb begin
      state_n   = state;
      cod_n     = cod;
      pin_n     = pin;
      val_n     = val;
      seen_n    = seen;
      key_err_n = 1'b0;
      timeout_n = 1'b0;
      done_n    = 1'b0;
      field     = 8'd0;
      fmax      = 8'd15;

      case (state)
         GET_COD: begin
            field = {3'd0, cod};
            fmax  = 8'd31;
         end
         GET_PIN: field = {4'd0, pin};
         GET_VAL: field = {4'd0, val};
         default: ;
      endcase
      // Candidate is deliberately kept at 8 bits; wrapped values are range-checked as-is.
      cand = field * 8'd10 + {4'd0, bus.key_code};

      case (state)
         IDLE: begin
            if (bus.key_valid && bus.key_code == KEY_ENTER) begin
               state_n = GET_COD;
               cod_n   = '0;
               pin_n   = '0;
               val_n   = '0;
               seen_n  = 1'b0;
            end
         end
         GET_COD, GET_PIN, GET_VAL: begin
            if (bus.key_valid) begin
               if (bus.key_code == KEY_CANCEL) begin
                  state_n = IDLE;
                  cod_n   = '0;
                  pin_n   = '0;
                  val_n   = '0;
               end else if (bus.key_code <= 4'd9) begin
                  if (cand <= fmax) begin
                     case (state)
                        GET_COD: cod_n = cand[4:0];
                        GET_PIN: pin_n = cand[3:0];
                        default: val_n = cand[3:0];
                     endcase
                     seen_n = 1'b1;
                  end else begin
                     key_err_n = 1'b1;
                  end
               end else if (bus.key_code == KEY_ENTER && seen) begin
                  state_n = (state == GET_COD) ? GET_PIN :
                            (state == GET_PIN) ? GET_VAL : REQUEST;
                  seen_n  = 1'b0;
               end else begin
                  key_err_n = 1'b1;
               end
            end else if (expire) begin
               state_n   = IDLE;
               cod_n     = '0;
               pin_n     = '0;
               val_n     = '0;
               timeout_n = 1'b1;
            end
         end
         REQUEST: begin
            if (bus.key_valid && bus.key_code == KEY_CANCEL) begin
               state_n = IDLE;
               cod_n   = '0;
               pin_n   = '0;
               val_n   = '0;
            end else if (bus.ack && enable_q) begin
               state_n = IDLE;
               done_n  = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cod       <= '0;
         pin       <= '0;
         val       <= '0;
         seen      <= 1'b0;
         enable_q  <= 1'b0;
         sel_q     <= 1'b0;
         key_err_q <= 1'b0;
         timeout_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state     <= state_n;
         cod       <= cod_n;
         pin       <= pin_n;
         val       <= val_n;
         seen      <= seen_n;
         enable_q  <= (state_n == REQUEST);
         sel_q     <= (state_n == GET_VAL);
         key_err_q <= key_err_n;
         timeout_q <= timeout_n;
         done_q    <= done_n;
      end
   end

`ifdef ATM_ENTRY_TIMEOUT_EN
   localparam logic [8:0] TMO_LOAD = 9'(TIMEOUT_CYCLES);

   logic [8:0] tempo, tempo_n;

   assign expire = (tempo == 9'd1);

   // A rejected key still counts down but parks at 1 so expiry fires on the next quiet cycle.
   always_comb begin
      if (state_n == IDLE)
         tempo_n = '0;
      else if (state == REQUEST)
         tempo_n = tempo;
      else if (bus.key_valid && !key_err_n)
         tempo_n = TMO_LOAD;
      else if (tempo > 9'd1)
         tempo_n = tempo - 9'd1;
      else
         tempo_n = tempo;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tempo <= '0;
      else
         tempo <= tempo_n;
   end

   assign bus.Tempo = tempo;
`else
   assign expire    = 1'b0;
   assign bus.Tempo = '0;
`endif

   assign bus.COD       = cod;
   assign bus.PIN       = pin;
   assign bus.VAL       = val;
   assign bus.ENABLE    = enable_q;
   assign bus.Seleciona = sel_q;
   assign bus.key_err   = key_err_q;
   assign bus.timeout   = timeout_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_atm_keypad_entry.sv
// tb/tb_atm_keypad_entry.sv - scoreboard bench for atm_keypad_entry against a session-level model
`timescale 1ns/1ps
module tb_atm_keypad_entry;

   localparam int TMO = 20;
`ifdef ATM_ENTRY_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic reset = 1'b0;

   atm_keypad_entry_if bus();

   atm_keypad_entry #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] cod;
      logic [3:0] pin;
      logic [3:0] val;
      logic       en;
      logic       sel;
      logic [8:0] tempo;
      logic       err;
      logic       to;
      logic       dn;
   } snap_t;

   snap_t       sbq[$];
   logic [12:0] reqq[$];
   int          checks = 0;
   int          errors = 0;

   // Session model: phase 0 idle, 1..3 = entering field phase-1, 4 = waiting on the core.
   int phase = 0;
   int fld[3] = '{0, 0, 0};
   int fmax[3] = '{31, 15, 15};
   bit seen = 1'b0;
   int tempo = 0;

   function automatic snap_t dut_outputs();
      return {bus.COD, bus.PIN, bus.VAL, bus.ENABLE, bus.Seleciona, bus.Tempo,
              bus.key_err, bus.timeout, bus.done};
   endfunction

   task automatic countdown();
      if (tempo > 1) tempo = tempo - 1;
   endtask

   task automatic model_step(input bit v, input int k, input bit a);
      snap_t s;
      int    i;
      int    cand;
      bit    err = 1'b0;
      bit    to  = 1'b0;
      bit    dn  = 1'b0;
      if (phase == 0) begin
         if (v && k == 10) begin
            phase = 1;
            fld   = '{0, 0, 0};
            seen  = 1'b0;
            tempo = TMO;
         end
      end else if (phase <= 3) begin
         i = phase - 1;
         if (v && k == 11) begin
            phase = 0;
            fld   = '{0, 0, 0};
            tempo = 0;
         end else if (v && k < 10) begin
            cand = (fld[i] * 10 + k) % 256;
            if (cand <= fmax[i]) begin
               fld[i] = cand;
               seen   = 1'b1;
               tempo  = TMO;
            end else begin
               err = 1'b1;
               countdown();
            end
         end else if (v && k == 10 && seen) begin
            phase = phase + 1;
            seen  = 1'b0;
            tempo = TMO;
            if (phase == 4) reqq.push_back({5'(fld[0]), 4'(fld[1]), 4'(fld[2])});
         end else if (v) begin
            err = 1'b1;
            countdown();
         end else if (TMO_EN && tempo == 1) begin
            phase = 0;
            fld   = '{0, 0, 0};
            tempo = 0;
            to    = 1'b1;
         end else begin
            countdown();
         end
      end else begin
         if (v && k == 11) begin
            phase = 0;
            fld   = '{0, 0, 0};
            tempo = 0;
            if (reqq.size() > 0) reqq.delete(reqq.size() - 1);
         end else if (a) begin
            phase = 0;
            tempo = 0;
            dn    = 1'b1;
         end
      end
      if (!TMO_EN) tempo = 0;
      s.cod   = 5'(fld[0]);
      s.pin   = 4'(fld[1]);
      s.val   = 4'(fld[2]);
      s.en    = (phase == 4);
      s.sel   = (phase == 3);
      s.tempo = 9'(tempo);
      s.err   = err;
      s.to    = to;
      s.dn    = dn;
      sbq.push_back(s);
   endtask

   task automatic step(input bit v, input int k, input bit a);
      @(negedge clk);
      bus.key_valid = v;
      bus.key_code  = 4'(k);
      bus.ack       = a;
      model_step(v, k, a);
   endtask

   task automatic press(input int k);
      step(1'b1, k, 1'b0);
   endtask

   task automatic idle(input int n);
      for (int j = 0; j < n; j++) step(1'b0, 0, 1'b0);
   endtask

   task automatic check_reset(input string tag);
      snap_t act;
      act = dut_outputs();
      checks++;
      if (act !== '0) begin
         errors++;
         $display("FAIL %s: outputs act=%h req=0", tag, act);
      end
   endtask

   // Monitor: one expected snapshot per clocked cycle, plus request contents on done.
   initial begin
      snap_t       e;
      snap_t       act;
      logic [12:0] r;
      forever begin
         @(posedge clk);
         #1;
         if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            act = dut_outputs();
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL outputs @%0t: act cod=%0d pin=%0d val=%0d en=%b sel=%b tempo=%0d err=%b to=%b dn=%b | req cod=%0d pin=%0d val=%0d en=%b sel=%b tempo=%0d err=%b to=%b dn=%b",
                        $time, act.cod, act.pin, act.val, act.en, act.sel, act.tempo, act.err, act.to, act.dn,
                        e.cod, e.pin, e.val, e.en, e.sel, e.tempo, e.err, e.to, e.dn);
            end
            if (act.dn === 1'b1) begin
               checks++;
               if (reqq.size() == 0) begin
                  errors++;
                  $display("FAIL done_request @%0t: act done with no pending request, req none", $time);
               end else begin
                  r = reqq.pop_front();
                  if ({act.cod, act.pin, act.val} !== r) begin
                     errors++;
                     $display("FAIL done_request @%0t: act %h req %h", $time, {act.cod, act.pin, act.val}, r);
                  end
               end
            end
         end
      end
   end

   initial begin
      int r;
      bit v;
      int k;
      bus.key_valid = 1'b0;
      bus.key_code  = 4'd0;
      bus.ack       = 1'b0;
      #1 reset = 1'b1;
      #2 check_reset("reset_initial");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Full session: COD=23, PIN=9, VAL=5, ack two cycles after ENTER.
      press(10); press(2); press(3); press(10);
      press(9);  press(10); press(5); press(10);
      idle(2);
      step(1'b0, 0, 1'b1);
      idle(3);

      // Range rejections and empty ENTER.
      press(10); press(4); press(0); press(10);
      press(1);  press(6); press(10);
      press(10); press(12); press(15);
      press(11);
      idle(2);

      // Ack outside REQUEST is ignored; truncated-candidate path (26*10+0 wraps to 4).
      step(1'b0, 0, 1'b1);
      press(10); press(2); press(6); press(0); press(11);

      // Inactivity expiry, then a digit landing on the last cycle.
      press(10); idle(TMO + 5);
      press(11);
      press(10); idle(TMO - 1); press(3); idle(4);
      press(11);

      // Cancel while requesting; later ack must not complete anything.
      press(10); press(1); press(10); press(2); press(10); press(3); press(10);
      idle(2); press(11); idle(1);
      step(1'b0, 0, 1'b1); idle(2);

      // Long wait in GET_VAL.
      press(10); press(1); press(10); press(1); press(10);
      idle(1000);
      press(11);

      // Asynchronous reset mid-GET_PIN with COD=7, then a fresh session.
      press(10); press(7); press(10); idle(2);
      bus.key_valid = 1'b0;
      bus.ack       = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset("reset_mid_pin");
      phase = 0;
      fld   = '{0, 0, 0};
      seen  = 1'b0;
      tempo = 0;
      reqq.delete();
      @(negedge clk);
      reset = 1'b0;
      press(10); press(1); press(8); press(10); press(7); press(10); press(9); press(10);
      step(1'b0, 0, 1'b1);
      idle(2);

      // Randomised traffic with occasional quiet stretches.
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            idle(TMO + 2);
         end else begin
            v = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 19);
            if (r < 10)      k = r;
            else if (r < 14) k = 10;
            else if (r == 14) k = 11;
            else             k = 12 + (r % 4);
            step(v, k, ($urandom_range(0, 3) == 0));
         end
      end
      idle(3);

      @(posedge clk);
      #2;
      checks++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: act %0d pending, req 0", sbq.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/atm_keypad_entry.md
Name: atm_keypad_entry

Overview:
- Front-end transaction initiator for the ATM datapath (PIN check, balance/value displays, timer, comparator).
- Collects decimal key presses from a keypad and assembles account code, PIN and withdrawal value.
- Presents the assembled request to the core on COD/PIN/VAL with an ENABLE/ack handshake.
- Runs an inactivity timer, exported on Tempo.

Parameters:
- TIMEOUT_CYCLES, 300, inactivity limit in clk cycles per entry state; must fit in 9 bits.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- key_valid  input  1  one-cycle strobe; key_code is valid this cycle.
- key_code  input  4  0–9 digit, 4'hA ENTER, 4'hB CANCEL; 4'hC–4'hF ignored.
- ack  input  1  core accepted the request.
- COD  output  5  account code, 0–31.
- PIN  output  4  PIN, 0–15.
- VAL  output  4  withdrawal value, 0–15.
- ENABLE  output  1  request valid to core.
- Seleciona  output  1  high while in GET_VAL (value path select).
- Tempo  output  9  remaining inactivity cycles.
- key_err  output  1  one-cycle pulse on a rejected key.
- timeout  output  1  one-cycle pulse on inactivity abort.
- done  output  1  one-cycle pulse when ack completes a request.

Behaviour:
- Single clock domain: clk. reset is asynchronous and active-high; all state is cleared immediately on assertion.
- Reset values: state IDLE; COD, PIN, VAL, Tempo = 0; ENABLE, Seleciona, key_err, timeout, done = 0.
- FSM states: IDLE, GET_COD, GET_PIN, GET_VAL, REQUEST.
- IDLE:
  - ENTER -> GET_COD; clears COD/PIN/VAL, loads Tempo = TIMEOUT_CYCLES.
  - Any other key is ignored, with no key_err.
- Entry states (GET_COD, GET_PIN, GET_VAL):
  - A digit d computes candidate = field*10 + d at 8-bit width.
  - If candidate <= field max (31 for COD, 15 for PIN/VAL), the field updates on the next edge. Otherwise the field holds and key_err pulses.
  - ENTER with at least one digit accepted in this state advances GET_COD -> GET_PIN -> GET_VAL -> REQUEST.
  - ENTER with no digit accepted: key_err pulses and the state holds.
  - Codes 4'hC–4'hF: key_err pulses, no other effect.
  - Every accepted key (digit or ENTER, not rejected) reloads Tempo = TIMEOUT_CYCLES.
  - Otherwise Tempo decrements by 1 per cycle. When Tempo == 1 and no key arrives, the next edge goes to IDLE, Tempo = 0, fields clear, timeout pulses.
  - A key arriving in the same cycle as expiry wins: it is processed and there is no timeout.
- CANCEL in any non-IDLE state:
  - Next edge goes to IDLE, fields clear, Tempo = 0, no pulse.
  - In REQUEST, ENABLE drops the same edge.
- REQUEST:
  - ENABLE = 1; COD/PIN/VAL held stable; key digits and ENTER ignored.
  - Tempo holds its value and does not count.
  - ack sampled high -> next edge goes to IDLE, ENABLE = 0, done pulses, fields are retained until the next session's ENTER.
  - ack while ENABLE = 0 is ignored.
- Seleciona is registered; it equals 1 exactly in the cycles the state is GET_VAL.
- key_valid with no edge-level decoding: each asserted cycle counts as one key.
- Latency: outputs reflect a key one clk edge after the strobe.

Optional Feature:
- Macro: ATM_ENTRY_TIMEOUT_EN.
- Defined: the inactivity timer operates as described.
- Undefined: the timer logic is removed, Tempo is tied to 0, timeout is tied to 0, and entry states wait indefinitely. All other behaviour is unchanged.

Test Plan:
- Reset mid-GET_PIN, COD=7 -> all outputs 0 asynchronously, state IDLE, ENTER restarts a session.
- Keys ENTER,2,3,ENTER,9,ENTER,5,ENTER, then ack two cycles later -> COD=23, PIN=9, VAL=5, ENABLE high until ack edge, done pulses once, Seleciona high only during GET_VAL.
- In GET_COD: keys 4,0 -> second digit rejected (40>31), key_err one pulse, COD=4. In GET_PIN: keys 1,6 -> PIN=1 with key_err. ENTER with no digit -> key_err, state holds.
- With ATM_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES=20: ENTER, then idle -> Tempo counts 20..1, timeout pulses, IDLE, COD=0. Repeat with a digit on the Tempo==1 cycle -> no timeout, Tempo reloads 20.
- CANCEL in REQUEST -> ENABLE low next edge, no done; a subsequent ack is ignored.
- Without the macro: idle 1000 cycles in GET_VAL -> state holds, Tempo=0, timeout never asserts.
